// File: rtl/clock_set_controller_if.sv
// Button/tick inputs and time/mode outputs of the wall-clock controller.
// The master side drives the buttons and tick. The slave side (the controller)
// drives the time fields and the mode indication.
interface clock_set_controller_if;
  logic       tick;
  logic       set;
  logic       op1;
  logic       op2;
  logic [5:0] seconds;
  logic [5:0] minutes;
  logic [4:0] hours;
  logic       isPM;
  logic [1:0] setMode;
  logic       blink;

  modport master (
    output tick, set, op1, op2,
    input  seconds, minutes, hours, isPM, setMode, blink
  );

  modport slave (
    input  tick, set, op1, op2,
    output seconds, minutes, hours, isPM, setMode, blink
  );
endinterface

// File: rtl/clock_set_controller.sv
// Wall-clock controller. It free-runs hh:mm:ss on a 1 Hz tick and provides a
// button-driven set mode. Set mode freezes time and edits one field at a time.
// It falls back to RUN after TIMEOUT_TICKS ticks with no button activity.
module clock_set_controller #(
  parameter int TIMEOUT_TICKS = 10,
  parameter int TW            = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  clock_set_controller_if.slave  bus
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] SET_HOUR = 2'd1;
  localparam logic [1:0] SET_MIN  = 2'd2;
  localparam logic [1:0] SET_SEC  = 2'd3;

  localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_TICKS);

  logic [5:0]    sec_q, sec_d;
  logic [5:0]    min_q, min_d;
  logic [4:0]    hr_q, hr_d;
  logic          pm_q, pm_d;
  logic [1:0]    mode_q, mode_d;
  logic          blink_q, blink_d;
  logic [TW-1:0] to_q, to_d;
  logic          set_prev_q, op1_prev_q, op2_prev_q;

  logic set_ev, op1_ev, op2_ev, inc_ev, dec_ev, any_ev;

  function automatic logic [5:0] inc60(input logic [5:0] v);
    return (v == 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [5:0] dec60(input logic [5:0] v);
    return (v == 6'd0) ? 6'd59 : v - 6'd1;
  endfunction

  function automatic logic [4:0] inc24(input logic [4:0] v);
    return (v == 5'd23) ? 5'd0 : v + 5'd1;
  endfunction

  function automatic logic [4:0] dec24(input logic [4:0] v);
    return (v == 5'd0) ? 5'd23 : v - 5'd1;
  endfunction

  // Rising-edge press detection; a held button yields a single event.
  always_comb begin
    set_ev = bus.set & ~set_prev_q;
    op1_ev = bus.op1 & ~op1_prev_q;
    op2_ev = bus.op2 & ~op2_prev_q;
    inc_ev = op1_ev & ~op2_ev;
    dec_ev = op2_ev & ~op1_ev;
    any_ev = set_ev | op1_ev | op2_ev;
  end

  // Next-state logic for the time fields, the mode, the timeout and blink.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
    sec_d   = sec_q;
    min_d   = min_q;
    hr_d    = hr_q;
    mode_d  = mode_q;
    to_d    = to_q;
    blink_d = blink_q;

    if (mode_q == RUN) begin
      blink_d = 1'b0;
      to_d    = '0;
      if (bus.tick) begin
        sec_d = inc60(sec_q);
        if (sec_q == 6'd59) begin
          min_d = inc60(min_q);
          if (min_q == 6'd59) hr_d = inc24(hr_q);
        end
      end
      if (set_ev) begin
        mode_d  = SET_HOUR;
        blink_d = 1'b1;
      end
    end else begin
      // Apply the edit to the current field before any mode advance.
      case (mode_q)
        SET_HOUR: if (inc_ev) hr_d = inc24(hr_q); else if (dec_ev) hr_d = dec24(hr_q);
        SET_MIN:  if (inc_ev) min_d = inc60(min_q); else if (dec_ev) min_d = dec60(min_q);
        default:  if (inc_ev) sec_d = inc60(sec_q); else if (dec_ev) sec_d = dec60(sec_q);
      endcase

      if (bus.tick) blink_d = ~blink_q;

      // Button activity restarts the inactivity window; otherwise count ticks.
      if (any_ev) begin
        to_d = '0;
      end else if (bus.tick) begin
        if (to_q + TW'(1) == TO_LIMIT) begin
          mode_d = RUN;
          to_d   = '0;
        end else begin
          to_d = to_q + TW'(1);
        end
      end

      if (set_ev) begin
        case (mode_q)
          SET_HOUR: mode_d = SET_MIN;
          SET_MIN:  mode_d = SET_SEC;
          default:  mode_d = RUN;
        endcase
      end

      if (mode_d == RUN) begin
        blink_d = 1'b0;
        to_d    = '0;
      end
    end

    pm_d = (hr_d >= 5'd12);
  end

  // State registers with synchronous reset that overrides every input.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      sec_q      <= '0;
      min_q      <= '0;
      hr_q       <= '0;
      pm_q       <= 1'b0;
      mode_q     <= RUN;
      blink_q    <= 1'b0;
      to_q       <= '0;
      set_prev_q <= 1'b0;
      op1_prev_q <= 1'b0;
      op2_prev_q <= 1'b0;
    end else begin
      sec_q      <= sec_d;
      min_q      <= min_d;
      hr_q       <= hr_d;
      pm_q       <= pm_d;
      mode_q     <= mode_d;
      blink_q    <= blink_d;
      to_q       <= to_d;
      set_prev_q <= bus.set;
      op1_prev_q <= bus.op1;
      op2_prev_q <= bus.op2;
    end
  end

  assign bus.seconds = sec_q;
  assign bus.minutes = min_q;
  assign bus.hours   = hr_q;
  assign bus.isPM    = pm_q;
  assign bus.setMode = mode_q;
  assign bus.blink   = blink_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller: reset, set-mode editing and wraps,
// midnight rollover, held-button behaviour, inactivity timeout and reset priority.
module tb_clock_set_controller;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  clock_set_controller_if bus ();

  clock_set_controller #(.TIMEOUT_TICKS(10), .TW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_time(input string tag, input int h, input int m, input int s);
    check({tag, ".hours"},   32'(bus.hours),   32'(h));
    check({tag, ".minutes"}, 32'(bus.minutes), 32'(m));
    check({tag, ".seconds"}, 32'(bus.seconds), 32'(s));
  endtask

  task automatic press_set();
    bus.set = 1'b1; step(); bus.set = 1'b0; step();
  endtask

  task automatic press_op1();
    bus.op1 = 1'b1; step(); bus.op1 = 1'b0; step();
  endtask

  task automatic press_op2();
    bus.op2 = 1'b1; step(); bus.op2 = 1'b0; step();
  endtask

  task automatic pulse_tick();
    bus.tick = 1'b1; step(); bus.tick = 1'b0;
  endtask

  initial begin
    bus.tick = 1'b0;
    bus.set  = 1'b0;
    bus.op1  = 1'b0;
    bus.op2  = 1'b0;
    reset    = 1'b1;

    // 1. Reset state
    step(); step();
    reset = 1'b0;
    step();
    check_time("reset", 0, 0, 0);
    check("reset.isPM",    32'(bus.isPM),    32'd0);
    check("reset.setMode", 32'(bus.setMode), 32'd0);
    check("reset.blink",   32'(bus.blink),   32'd0);

    // Buttons other than set are ignored in RUN
    press_op1();
    press_op2();
    check_time("run_ignore_ops", 0, 0, 0);

    // 3. SET_HOUR edits and wraps
    press_set();
    check("enter.setMode", 32'(bus.setMode), 32'd1);
    check("enter.blink",   32'(bus.blink),   32'd1);
    press_op2();
    check("hr_dec_wrap.hours", 32'(bus.hours), 32'd23);
    check("hr_dec_wrap.isPM",  32'(bus.isPM),  32'd1);
    press_op1();
    check("hr_inc_wrap.hours", 32'(bus.hours), 32'd0);
    check("hr_inc_wrap.isPM",  32'(bus.isPM),  32'd0);
    bus.op1 = 1'b1;
    for (int i = 0; i < 50; i++) step();
    bus.op1 = 1'b0;
    step();
    check("held_op1.hours", 32'(bus.hours), 32'd1);
    // Simultaneous op1/op2 edges cancel
    bus.op1 = 1'b1; bus.op2 = 1'b1; step();
    bus.op1 = 1'b0; bus.op2 = 1'b0; step();
    check("both_ops.hours", 32'(bus.hours), 32'd1);
    press_op2();
    press_op2();
    check("hr_preload.hours", 32'(bus.hours), 32'd23);

    // 4. SET_MIN wrap without carry, time frozen on ticks
    press_set();
    check("to_min.setMode", 32'(bus.setMode), 32'd2);
    press_op2();
    check("min_dec_wrap.minutes", 32'(bus.minutes), 32'd59);
    press_op1();
    check_time("min_inc_wrap", 23, 0, 0);
    press_op2();
    for (int i = 0; i < 5; i++) begin
      pulse_tick();
      step();
    end
    check_time("frozen_set_min", 23, 59, 0);
    check("frozen_set_min.blink",   32'(bus.blink),   32'd0);
    check("frozen_set_min.setMode", 32'(bus.setMode), 32'd2);

    // SET_SEC preload to 58, then back to RUN
    press_set();
    check("to_sec.setMode", 32'(bus.setMode), 32'd3);
    press_op2();
    press_op2();
    check("sec_preload.seconds", 32'(bus.seconds), 32'd58);
    press_set();
    check("to_run.setMode", 32'(bus.setMode), 32'd0);
    check("to_run.blink",   32'(bus.blink),   32'd0);

    // 2. Rollover through midnight
    pulse_tick();
    check_time("tick1", 23, 59, 59);
    check("tick1.isPM", 32'(bus.isPM), 32'd1);
    pulse_tick();
    check_time("tick2", 0, 0, 0);
    check("tick2.isPM", 32'(bus.isPM), 32'd0);

    // 5a. Timeout with no presses
    press_set();
    for (int i = 0; i < 9; i++) begin
      pulse_tick();
      step();
    end
    check("to_tick9.setMode", 32'(bus.setMode), 32'd1);
    pulse_tick();
    check("to_tick10.setMode", 32'(bus.setMode), 32'd0);
    check("to_tick10.blink",   32'(bus.blink),   32'd0);
    check_time("to_tick10", 0, 0, 0);
    step();
    pulse_tick();
    check_time("to_tick11", 0, 0, 1);

    // 5b. An op1 press on tick 9 restarts the window
    press_set();
    for (int i = 0; i < 8; i++) begin
      pulse_tick();
      step();
    end
    bus.tick = 1'b1; bus.op1 = 1'b1; step();
    bus.tick = 1'b0; bus.op1 = 1'b0; step();
    pulse_tick();
    check("to_restart.setMode", 32'(bus.setMode), 32'd1);
    check_time("to_restart", 1, 0, 1);

    // 6. Reset in SET_SEC with a simultaneous op1 edge
    step();
    press_set();
    press_set();
    check("pre_reset.setMode", 32'(bus.setMode), 32'd3);
    reset = 1'b1; bus.op1 = 1'b1; step();
    reset = 1'b0; bus.op1 = 1'b0; step();
    check_time("reset_mid_set", 0, 0, 0);
    check("reset_mid_set.setMode", 32'(bus.setMode), 32'd0);
    check("reset_mid_set.isPM",    32'(bus.isPM),    32'd0);
    check("reset_mid_set.blink",   32'(bus.blink),   32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
